// File: rtl/fifo_reader.sv
// Read-side FIFO consumer: pops show-ahead FIFO words into a 2-entry skid buffer,
// presents them on a valid/ready stream framed into fixed-length bursts, and counts pops.
module fifo_reader #(
    parameter int DSIZE = 8,
    parameter int BURST = 4,
    parameter int CNTW  = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic             enable,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [CNTW-1:0]  rd_count
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] BEAT_MAX = BW'(BURST - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t             occ;
    occ_t             occ_next;
    logic [DSIZE-1:0] head_q;
    logic [DSIZE-1:0] spare_q;
    logic             valid_q;
    logic [BW-1:0]    beat;
    logic [CNTW-1:0]  count_q;
    logic             push;
    logic             pop;
    logic             load_head_fifo;
    logic             load_head_spare;
    logic             load_spare;

    // Pop strobe looks only at our own occupancy so it never waits on m_ready;
    // gating with rrst_n keeps the FIFO untouched while reset is held.
    always_comb begin
        push            = rrst_n & enable & ~rempty & (occ != TWO);
        pop             = valid_q & m_ready;
        occ_next        = occ;
        load_head_fifo  = 1'b0;
        load_head_spare = 1'b0;
        load_spare      = 1'b0;
        case (occ)
            EMPTY: begin
                if (push) begin
                    occ_next       = ONE;
                    load_head_fifo = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head_fifo = 1'b1;
                end else if (push) begin
                    occ_next   = TWO;
                    load_spare = 1'b1;
                end else if (pop) begin
                    occ_next = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    occ_next        = ONE;
                    load_head_spare = 1'b1;
                end
            end
            default: occ_next = EMPTY;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ     <= EMPTY;
            valid_q <= 1'b0;
        end else begin
            occ     <= occ_next;
            valid_q <= (occ_next != EMPTY);
        end
    end

    // The head register is what m_data shows; the spare only fills under backpressure.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            head_q  <= '0;
            spare_q <= '0;
        end else begin
            if (load_head_fifo) begin
                head_q <= rdata;
            end else if (load_head_spare) begin
                head_q <= spare_q;
            end
            if (load_spare) begin
                spare_q <= rdata;
            end
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            beat    <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                beat <= (beat == BEAT_MAX) ? '0 : beat + BW'(1);
            end
            if (push) begin
                count_q <= count_q + CNTW'(1);
            end
        end
    end

    assign rinc     = push;
    assign m_data   = head_q;
    assign m_valid  = valid_q;
    assign m_last   = valid_q & (beat == BEAT_MAX);
    assign rd_count = count_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a show-ahead FIFO model feeds two instances,
// the default one and a CNTW=4 copy used to observe counter wrap.
module tb_fifo_reader;

    logic        rclk;
    logic        rrst_n;
    logic [7:0]  rdata;
    logic        rempty;
    logic        rinc;
    logic        rinc_w;
    logic        enable;
    logic [7:0]  m_data;
    logic [7:0]  m_data_w;
    logic        m_valid;
    logic        m_valid_w;
    logic        m_ready;
    logic        m_last;
    logic        m_last_w;
    logic [15:0] rd_count;
    logic [3:0]  rd_count_w;

    logic [7:0]  mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          checks = 0;
    int          errors = 0;

    fifo_reader #(.DSIZE(8), .BURST(4), .CNTW(16)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
        .enable(enable), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .rd_count(rd_count)
    );

    fifo_reader #(.DSIZE(8), .BURST(4), .CNTW(4)) dut_w (
        .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc_w),
        .enable(enable), .m_data(m_data_w), .m_valid(m_valid_w), .m_ready(m_ready),
        .m_last(m_last_w), .rd_count(rd_count_w)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    assign rempty = (wr_ptr == rd_ptr);
    assign rdata  = mem[rd_ptr[5:0]];

    always @(posedge rclk) begin
        if (rinc) rd_ptr <= rd_ptr + 1;
    end

    task automatic next_cycle();
        @(posedge rclk);
        #2;
    endtask

    task automatic load_word(input logic [7:0] value);
        mem[wr_ptr[5:0]] = value;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset();
        rrst_n  = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        next_cycle();
        load_word(8'hAA);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %0b expected 0", m_last); end
        checks++; if (rd_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", rd_count); end
        checks++; if (rinc !== 1'b0) begin errors++; $display("[TB] FAIL reset_rinc: got %0b expected 0", rinc); end
        wr_ptr = rd_ptr;
        next_cycle();
        rrst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_streaming();
        int k = 0;
        int first = -1;
        int lastc = -1;
        logic [7:0] exp_d;
        logic       exp_l;
        for (int i = 0; i < 8; i++) load_word(8'h10 + i[7:0]);
        #1;
        for (int cyc = 0; cyc < 30 && k < 8; cyc++) begin
            if (m_valid) begin
                exp_d = 8'h10 + k[7:0];
                exp_l = (k % 4 == 3);
                if (first < 0) first = cyc;
                lastc = cyc;
                checks++; if (m_data !== exp_d) begin errors++; $display("[TB] FAIL stream_data: got %0h expected %0h", m_data, exp_d); end
                checks++; if (m_last !== exp_l) begin errors++; $display("[TB] FAIL stream_last: got %0b expected %0b at %0h", m_last, exp_l, exp_d); end
                k++;
            end
            next_cycle();
        end
        checks++; if (k != 8) begin errors++; $display("[TB] FAIL stream_beats: got %0d expected 8", k); end
        checks++; if (lastc - first != 7) begin errors++; $display("[TB] FAIL stream_gapless: got span %0d expected 7", lastc - first); end
        checks++; if (rd_count !== 16'd8) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 8", rd_count); end
        checks++; if (rinc !== 1'b0) begin errors++; $display("[TB] FAIL stream_rinc_idle: got %0b expected 0", rinc); end
    endtask

    task automatic test_backpressure();
        int k = 0;
        logic [7:0] exp_d;
        logic       exp_l;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) load_word(8'h20 + i[7:0]);
        repeat (5) next_cycle();
        checks++; if (rd_count !== 16'd10) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 10", rd_count); end
        checks++; if (rinc !== 1'b0) begin errors++; $display("[TB] FAIL bp_rinc: got %0b expected 0", rinc); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: got %0b expected 1", m_valid); end
        checks++; if (m_data !== 8'h20) begin errors++; $display("[TB] FAIL bp_hold_data: got %0h expected 20", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_last: got %0b expected 0", m_last); end
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
            if (m_valid) begin
                exp_d = 8'h20 + k[7:0];
                exp_l = (k == 3);
                checks++; if (m_data !== exp_d) begin errors++; $display("[TB] FAIL bp_drain_data: got %0h expected %0h", m_data, exp_d); end
                checks++; if (m_last !== exp_l) begin errors++; $display("[TB] FAIL bp_drain_last: got %0b expected %0b", m_last, exp_l); end
                k++;
            end
            next_cycle();
        end
        checks++; if (k != 4) begin errors++; $display("[TB] FAIL bp_drain_beats: got %0d expected 4", k); end
        checks++; if (rd_count !== 16'd12) begin errors++; $display("[TB] FAIL bp_final_count: got %0d expected 12", rd_count); end
    endtask

    task automatic test_enable_gating();
        int k = 0;
        logic [7:0] exp_d;
        enable  = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) load_word(8'h30 + i[7:0]);
        #1;
        checks++; if (rinc !== 1'b0) begin errors++; $display("[TB] FAIL en_gate_rinc: got %0b expected 0", rinc); end
        enable = 1'b1;
        next_cycle();
        enable = 1'b0;
        #1;
        checks++; if (rinc !== 1'b0) begin errors++; $display("[TB] FAIL en_off_rinc: got %0b expected 0", rinc); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL en_buf_valid: got %0b expected 1", m_valid); end
        checks++; if (m_data !== 8'h30) begin errors++; $display("[TB] FAIL en_buf_data: got %0h expected 30", m_data); end
        m_ready = 1'b1;
        next_cycle();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL en_drained_valid: got %0b expected 0", m_valid); end
        repeat (2) next_cycle();
        checks++; if (rd_count !== 16'd13) begin errors++; $display("[TB] FAIL en_hold_count: got %0d expected 13", rd_count); end
        enable = 1'b1;
        #1;
        for (int cyc = 0; cyc < 20 && k < 2; cyc++) begin
            if (m_valid) begin
                exp_d = 8'h31 + k[7:0];
                checks++; if (m_data !== exp_d) begin errors++; $display("[TB] FAIL en_resume_data: got %0h expected %0h", m_data, exp_d); end
                checks++; if (m_last !== 1'b0) begin errors++; $display("[TB] FAIL en_resume_last: got %0b expected 0", m_last); end
                k++;
            end
            next_cycle();
        end
        checks++; if (rd_count !== 16'd15) begin errors++; $display("[TB] FAIL en_resume_count: got %0d expected 15", rd_count); end
    endtask

    task automatic test_empty_boundary();
        int rinc_cnt = 0;
        int valid_cnt = 0;
        load_word(8'h40);
        #1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (rinc) rinc_cnt++;
            if (m_valid) begin
                valid_cnt++;
                checks++; if (m_data !== 8'h40) begin errors++; $display("[TB] FAIL empty_data: got %0h expected 40", m_data); end
                checks++; if (m_last !== 1'b1) begin errors++; $display("[TB] FAIL empty_last: got %0b expected 1", m_last); end
            end
            next_cycle();
        end
        checks++; if (rinc_cnt != 1) begin errors++; $display("[TB] FAIL empty_rinc_pulses: got %0d expected 1", rinc_cnt); end
        checks++; if (valid_cnt != 1) begin errors++; $display("[TB] FAIL empty_valid_cycles: got %0d expected 1", valid_cnt); end
        checks++; if (rd_count !== 16'd16) begin errors++; $display("[TB] FAIL empty_count: got %0d expected 16", rd_count); end
    endtask

    task automatic test_reset_mid_burst();
        int k = 0;
        logic [7:0] exp_d;
        logic       exp_l;
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) load_word(8'h50 + i[7:0]);
        repeat (3) next_cycle();
        m_ready = 1'b0;
        next_cycle();
        #1;
        checks++; if (rinc !== 1'b0) begin errors++; $display("[TB] FAIL mid_full_rinc: got %0b expected 0", rinc); end
        checks++; if (m_data !== 8'h52) begin errors++; $display("[TB] FAIL mid_head_data: got %0h expected 52", m_data); end
        checks++; if (rd_count !== 16'd20) begin errors++; $display("[TB] FAIL mid_pre_count: got %0d expected 20", rd_count); end
        #2;
        rrst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %0b expected 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_data: got %0h expected 0", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_last: got %0b expected 0", m_last); end
        checks++; if (rd_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_rst_count: got %0d expected 0", rd_count); end
        checks++; if (rinc !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_rinc: got %0b expected 0", rinc); end
        repeat (2) next_cycle();
        rrst_n  = 1'b1;
        m_ready = 1'b1;
        #1;
        for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
            if (m_valid) begin
                exp_d = 8'h54 + k[7:0];
                exp_l = (k == 3);
                checks++; if (m_data !== exp_d) begin errors++; $display("[TB] FAIL mid_after_data: got %0h expected %0h", m_data, exp_d); end
                checks++; if (m_last !== exp_l) begin errors++; $display("[TB] FAIL mid_after_last: got %0b expected %0b", m_last, exp_l); end
                k++;
            end
            next_cycle();
        end
        checks++; if (k != 4) begin errors++; $display("[TB] FAIL mid_after_beats: got %0d expected 4", k); end
        checks++; if (rd_count !== 16'd4) begin errors++; $display("[TB] FAIL mid_after_count: got %0d expected 4", rd_count); end
    endtask

    task automatic test_counter_wrap();
        rrst_n = 1'b0;
        next_cycle();
        rrst_n = 1'b1;
        for (int i = 0; i < 17; i++) load_word(8'h60 + i[7:0]);
        repeat (25) next_cycle();
        checks++; if (rd_count_w !== 4'd1) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 1", rd_count_w); end
        checks++; if (rd_count !== 16'd17) begin errors++; $display("[TB] FAIL wrap_wide_count: got %0d expected 17", rd_count); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_idle_valid: got %0b expected 0", m_valid); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_enable_gating();
        test_empty_boundary();
        test_reset_mid_burst();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
